instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage of the single-issue RV32I core, sitting directly upstream of the combinational instruction ROM and downstream-feeding the decoder. Holds the program counter, drives the ROM byte address, and captures the returned word into a registered IF/ID slot with a valid/ready handshake. Handles stall, branch/jump redirect with flush, and fetch faults (misaligned or out-of-range PC).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ROM_DEPTH, 64, instruction ROM depth in words; legal PCs are 0 .. 4*ROM_DEPTH-4
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- instr_rAddr  out  32  byte address to ROM; equals the PC register
- instr_opcode  in  32  ROM word for instr_rAddr, combinational in the same cycle
- redirect_valid  in  1  branch/jump taken; PC must change this cycle
- redirect_addr  in  32  redirect target byte address
- id_ready  in  1  decoder accepts the IF/ID slot this cycle
- id_valid  out  1  IF/ID slot holds a valid instruction
- id_instr  out  32  captured instruction word
- id_pc  out  32  PC of id_instr
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32
- fetch_err  out  1  sticky fault flag; set in HALT
- fetch_count  out  32  number of instructions handed to the decoder

## Operation
- States: RUN, HALT. Reset enters RUN.
- load = (state == RUN) && (!id_valid || id_ready) && !redirect_valid && pc_legal.
- pc_legal = pc[1:0] == 0 && pc < 4*ROM_DEPTH.
- On load: id_instr <= instr_opcode, id_pc <= pc, id_valid <= 1, pc <= pc + 4.
- No load, no redirect, id_valid && !id_ready: stall; PC and IF/ID hold unchanged.
- Transfer = id_valid && id_ready && !redirect_valid; fetch_count increments by 1 per transfer (wraps at 2^32). Transfer and load in the same cycle is normal back-to-back flow.
- Redirect (highest priority in RUN): pc <= redirect_addr, id_valid <= 0, id_instr <= NOP (32'h0000_0013). The slot is discarded even if id_ready is high; no transfer counted.
- Redirect target illegal (misaligned or ≥ 4*ROM_DEPTH): pc <= redirect_addr, state <= HALT, fetch_err <= 1.
- Sequential PC reaching an illegal value in RUN (no redirect): state <= HALT, fetch_err <= 1, id_valid clears once the held slot transfers; PC holds.
- HALT: no loads, redirect ignored, PC held; pending valid slot may still transfer. Exit only by reset.

## Timing
- Reset values: pc = instr_rAddr = RESET_PC, id_valid = 0, id_instr = 32'h0000_0013, id_pc = 0, id_pc_plus4 = 4, fetch_err = 0, fetch_count = 0, state = RUN.
- Fetch latency: one cycle; word at PC P appears on id_instr with id_valid = 1 the cycle after P is on instr_rAddr.
- Throughput: one instruction per cycle with id_ready held high.
- Redirect penalty: one bubble; target instruction valid two edges after redirect_valid is sampled.
- Reset asserted mid-run: all outputs take reset values asynchronously, no partial update on the next edge.
- id_* outputs are stable while id_valid && !id_ready (no redirect).

## Structure
- Shared package core_pkg: NOP_INSTR constant, fetch_state_t enum {RUN, HALT}, default RESET_PC.
- One natural sub-module: if_id_reg (valid/instr/pc slot with load and flush inputs); PC register, FSM and counter stay in instr_fetch.
- ROM is instantiated by the parent, not inside this block.

## Test plan
- Reset, id_ready=1, ROM loaded with ten R-type words: id_instr = 32'h004182B3, 32'h404182B3, … one per cycle, id_pc 0,4,…,36, fetch_count = 10 after ten transfers.
- id_ready low 3 cycles at id_pc = 8: id_instr/id_pc frozen, instr_rAddr = 12 held, fetch_count unchanged; resumes with id_pc = 12 next.
- redirect_valid with redirect_addr = 32'h0000_0004 while id_pc = 20 and id_ready = 1: next cycle id_valid = 0, count not incremented; following cycle id_pc = 4, id_instr = 32'h404182B3.
- redirect_addr = 32'h0000_0006: fetch_err = 1, state HALT, id_valid stays 0, later redirects ignored.
- Sequential run to PC = 256 with ROM_DEPTH = 64: last valid id_pc = 252, then fetch_err = 1, instr_rAddr held at 256.
- Assert reset asynchronously mid-cycle during a stall: outputs immediately return to reset values; after release, first id_pc = RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end: fetch FSM states,
// the canonical NOP encoding and the PC legality rule.
package core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // A PC is fetchable when word aligned and inside the ROM.
  function automatic logic pc_is_legal(input logic [31:0] pc, input int unsigned depth);
    return (pc[1:0] == 2'b00) && ({1'b0, pc} < (33'(depth) << 2));
  endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline slot: holds one fetched instruction and its PC.
// Priority is flush over load over consume.
module if_id_reg
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        consume_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, RUN/HALT fault FSM, redirect/flush,
// transfer counter, and the IF/ID slot feeding the decoder.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned ROM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_rAddr,
  input  logic [31:0] instr_opcode,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         load, flush, transfer;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    load     = 1'b0;
    flush    = 1'b0;
    transfer = id_valid && id_ready;

    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d     = redirect_addr;
          flush    = 1'b1;
          transfer = 1'b0;
          if (!pc_is_legal(redirect_addr, ROM_DEPTH)) state_d = HALT;
        end else if (!pc_is_legal(pc_q, ROM_DEPTH)) begin
          state_d = HALT;
        end else if (!id_valid || id_ready) begin
          load = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      // Halted: redirects ignored, PC frozen; a pending slot may still drain.
      HALT: ;
      default: state_d = HALT;
    endcase

    count_d = count_q + 32'(transfer);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .load_i    (load),
    .consume_i (transfer),
    .instr_i   (instr_opcode),
    .pc_i      (pc_q),
    .valid_o   (id_valid),
    .instr_o   (id_instr),
    .pc_o      (id_pc)
  );

  assign instr_rAddr = pc_q;
  assign id_pc_plus4 = id_pc + 32'd4;
  assign fetch_err   = (state_q == HALT);
  assign fetch_count = count_q;

endmodule
